loop_nest_ctrl: RTL
===================

LOOP_NEST_CTRL -- requirements
Module: loop_nest_ctrl

Interface
REQ-001 Parameter: DW, default 8, width of every loop index and bound.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  launch request; sampled only in IDLE.
REQ-005 abort  input  1  terminate current sweep; sampled in RUN.
REQ-006 max0/max1/max2  input  DW each  inclusive bounds, inner/middle/outer loop; captured at launch.
REQ-007 out_valid  output  1  current index tuple valid.
REQ-008 out_ready  input  1  consumer accepts tuple.
REQ-009 idx0/idx1/idx2  output  DW each  current inner/middle/outer index.
REQ-010 co  output  3  per-level wrap flag for current tuple; bit k = idx0..idxk all at their bounds.
REQ-011 last  output  1  current tuple is final tuple of sweep (co[2]).
REQ-012 busy  output  1  high in RUN and DONE.
REQ-013 done  output  1  one-cycle pulse at sweep end (normal or aborted).
REQ-014 aborted  output  1  qualifies done: 1 = sweep ended by abort.

Function
REQ-015 States: IDLE, RUN, DONE; encoding implementation-defined.
REQ-016 IDLE: start=1 -> capture max0..2 into internal registers, clear idx0..2 to 0, go RUN next cycle.
REQ-017 start while busy ignored; bound inputs changed during RUN have no effect.
REQ-018 RUN: out_valid=1 every cycle; IDLE/DONE: out_valid=0.
REQ-019 Beat = out_valid & out_ready; indices advance only on beat; no beat -> tuple and co held stable.
REQ-020 On beat: idx0 < bound0 -> idx0+1; else idx0=0 and idx1 advances by same rule; idx1 wrap advances idx2.
REQ-021 Comparison is unsigned `idx < bound`; an index already >= its bound wraps to 0 (no overflow past 2^DW-1).
REQ-022 co[0]=(idx0==bound0); co[1]=co[0]&(idx1==bound1); co[2]=co[1]&(idx2==bound2); all gated by RUN.
REQ-023 Beat with last=1 -> no index advance, go DONE; DONE lasts exactly one cycle, done=1, aborted=0, then IDLE.
REQ-024 Total beats per sweep = (bound0+1)*(bound1+1)*(bound2+1); tuples in row-major order, idx0 fastest.
REQ-025 All bounds 0 -> single tuple (0,0,0) with last=1.
REQ-026 abort=1 in RUN -> DONE next cycle with aborted=1; a beat in the abort cycle is accepted by consumer but index advance discarded.
REQ-027 abort and last-beat same cycle -> aborted=1.
REQ-028 abort in IDLE/DONE ignored.
REQ-029 Latency: start cycle N -> out_valid=1 at cycle N+1; last beat cycle M -> done=1 at M+1; start accepted at M+2 earliest.
REQ-030 aborted holds its value until next launch; done is the strobe.

Reset
REQ-031 rst=1 at clock edge -> IDLE; idx0..2=0, stored bounds=0, out_valid=0, busy=0, done=0, aborted=0, co=0.
REQ-032 Reset mid-RUN or in DONE terminates immediately with no done pulse; start in same cycle as rst ignored.

Verification
REQ-033 bounds (2,1,1), out_ready=1 -> 12 beats, tuples (0,0,0),(1,0,0),(2,0,0),(0,1,0)...(2,1,1); last only on 12th; done one cycle later, aborted=0.
REQ-034 bounds (0,0,0) -> one beat (0,0,0), co=3'b111, last=1; done next cycle.
REQ-035 bounds (3,0,0), out_ready toggling 1,0,1,0 -> indices change only on beat cycles; co/idx stable while out_ready=0; 4 beats total.
REQ-036 bounds (255,255,0), DW=8 -> idx0 wraps 255->0 and idx1 increments on same beat; 65536 beats; no overflow.
REQ-037 bounds (5,5,5), abort after 7th beat -> done next cycle with aborted=1, busy low after; start with max inputs changed mid-sweep -> new sweep uses new bounds, previous ones ignored.
REQ-038 rst asserted at beat 3 of a (4,4,4) sweep -> next cycle all outputs reset values, no done; fresh start runs full 125 beats.

Source files
------------

// File: rtl/loop_nest_ctrl.sv
// ============================================================================
// Module  : loop_nest_ctrl
// Brief   : Three-level loop-nest index generator with ready/valid handshake,
//           per-level wrap flags, abort and done/aborted completion status.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module loop_nest_ctrl #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] max0,
  input  logic [DW-1:0] max1,
  input  logic [DW-1:0] max2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] idx0,
  output logic [DW-1:0] idx1,
  output logic [DW-1:0] idx2,
  output logic [2:0]    co,
  output logic          last,
  output logic          busy,
  output logic          done,
  output logic          aborted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_bnd0, r_bnd1, r_bnd2;
  logic [DW-1:0] r_idx0, r_idx1, r_idx2;
  logic          r_valid;
  logic          r_busy;
  logic          r_done;
  logic          r_aborted;

  logic          w_beat;
  logic          w_wrap0, w_wrap1;
  logic [2:0]    w_co;

  assign w_beat  = r_valid & out_ready;
  // An index at or above its bound wraps to zero, so the index never overflows.
  assign w_wrap0 = !(r_idx0 < r_bnd0);
  assign w_wrap1 = !(r_idx1 < r_bnd1);

  assign w_co[0] = r_valid & (r_idx0 == r_bnd0);
  assign w_co[1] = w_co[0] & (r_idx1 == r_bnd1);
  assign w_co[2] = w_co[1] & (r_idx2 == r_bnd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bnd0    <= '0;
      r_bnd1    <= '0;
      r_bnd2    <= '0;
      r_idx0    <= '0;
      r_idx1    <= '0;
      r_idx2    <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_bnd0    <= max0;
            r_bnd1    <= max1;
            r_bnd2    <= max2;
            r_idx0    <= '0;
            r_idx1    <= '0;
            r_idx2    <= '0;
            r_valid   <= 1'b1;
            r_busy    <= 1'b1;
            r_aborted <= 1'b0;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          // Abort wins over a simultaneous final beat; any beat advance is dropped.
          if (abort) begin
            r_valid   <= 1'b0;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
            r_state   <= S_DONE;
          end else if (w_beat && w_co[2]) begin
            r_valid   <= 1'b0;
            r_done    <= 1'b1;
            r_aborted <= 1'b0;
            r_state   <= S_DONE;
          end else if (w_beat) begin
            r_idx0 <= w_wrap0 ? '0 : r_idx0 + 1'b1;
            if (w_wrap0) begin
              r_idx1 <= w_wrap1 ? '0 : r_idx1 + 1'b1;
              if (w_wrap1) begin
                r_idx2 <= (r_idx2 < r_bnd2) ? r_idx2 + 1'b1 : '0;
              end
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign out_valid = r_valid;
  assign idx0      = r_idx0;
  assign idx1      = r_idx1;
  assign idx2      = r_idx2;
  assign co        = w_co;
  assign last      = w_co[2];
  assign busy      = r_busy;
  assign done      = r_done;
  assign aborted   = r_aborted;

endmodule

`default_nettype wire
